snd_dsd_serializer: RTL and testbench
=====================================

Name: snd_dsd_serializer

Overview:
- Downstream consumer of the snd_mclkdiv BCLK output (BCLK = MCLK/2, high on odd clkcnt) in the DSD DAC IP.
- Takes parallel stereo DSD words over a valid/ready handshake into a one-deep holding buffer.
- Serializes words MSB-first onto DSD_L/DSD_R with an aligned DSD_CLK.
- Inserts the DSD silence pattern when disabled or starved, and flags underrun.

Parameters:
- WORD_W, 32, bits per channel word; must be a multiple of 8 and >= 8.
- IDLE_BYTE, 8'h69, DSD silence byte, replicated WORD_W/8 times to form the idle word.

Ports:
- MCLK  in  1  master clock; only clock.
- MRST  in  1  reset; asynchronous, active-low.
- BCLK  in  1  bit clock from snd_mclkdiv, synchronous to MCLK; used as a tick source, never as a clock.
- EN  in  1  stream enable.
- S_DATA_L  in  WORD_W  left word.
- S_DATA_R  in  WORD_W  right word.
- S_VALID  in  1  input word valid.
- S_READY  out  1  holding buffer can accept a word.
- DSD_CLK  out  1  DSD bit clock to the DAC.
- DSD_L  out  1  left DSD bit.
- DSD_R  out  1  right DSD bit.
- UNDERRUN  out  1  sticky starvation flag.
- CLR_UNDERRUN  in  1  single-cycle clear of UNDERRUN.

Behaviour:
- Reset (MRST=0, async):
  - bclk_d=0, DSD_CLK=0.
  - Both shift registers = idle word, so DSD_L=DSD_R=0 (MSB of 0x69).
  - bitcnt=WORD_W-1, hold_valid=0, S_READY=0, UNDERRUN=0, state=IDLE.
- Tick generation:
  - bclk_d <= BCLK every MCLK.
  - DSD_CLK = bclk_d (registered output).
  - fall = bclk_d & ~BCLK. All shift and load actions happen only on fall, i.e. once per 2 MCLK.
  - Data changes in the same cycle DSD_CLK goes low, so data is stable across the DSD_CLK rising edge.
- Handshake:
  - S_READY = ~hold_valid & (state != IDLE). Registered-only path, no combinational dependence on S_VALID.
  - Accept when S_VALID & S_READY: hold_L/R captured, hold_valid <= 1 next cycle.
  - S_DATA must be stable only in the accept cycle.
- Shift rule on fall:
  - If bitcnt != WORD_W-1: shift left by 1 (LSB fill 0), bitcnt++.
  - Else (word boundary): bitcnt <= 0 and load per the state machine below.
- DSD_L/DSD_R = MSB of their shift registers (registered).
- State machine (transitions evaluated only at a word boundary, except EN-driven exits):
  - IDLE: boundary loads the idle word. EN=1 moves to PRIME immediately (next MCLK).
  - PRIME: boundary with hold_valid loads hold, clears hold_valid, goes to RUN. Without hold_valid it loads the idle word with no underrun.
  - RUN: boundary with hold_valid loads hold and clears it. Without hold_valid it loads the idle word and sets UNDERRUN.
  - EN=0 in PRIME or RUN: the current word completes. At the next boundary the idle word is loaded, hold_valid is cleared (the held word is discarded), and state goes to IDLE.
- Simultaneous events:
  - Accept and boundary load cannot coincide with hold_valid=1, because S_READY=0 then.
  - Accept in the boundary cycle while the hold is empty: underrun is still taken; the accepted word is used at the next boundary.
  - Set and CLR_UNDERRUN in the same cycle: set wins.
- Latency: from the first accepted word in PRIME, the first bit appears at the next word boundary, at most WORD_W fall ticks = 2*WORD_W MCLK.
- Reset mid-word: immediate return to reset values; partial word lost.

Decomposition:
- Package snd_dsd_pkg holds:
  - state enum {IDLE, PRIME, RUN}
  - IDLE_BYTE default
  - function idle_word(WORD_W) replicating IDLE_BYTE
- Sub-module snd_dsd_chshift: one channel shift register with load/shift enables and MSB output, instantiated twice (L/R).
- Tick/edge logic, hold buffer, bitcnt and FSM stay in the top.

Test Plan:
- Reset with BCLK toggling and EN=0 -> DSD_L/R stream 0x69696969 MSB-first; S_READY=0; UNDERRUN=0.
- EN=1, single accept L=0xF0F0F0F0, R=0x0000FFFF -> S_READY drops for the word. The next boundary starts L bits 1,1,1,1,0,0,0,0,... and R 16 zeros then 16 ones. Each bit is held exactly 2 MCLK, and DSD_CLK rises mid-bit.
- Back-to-back words A=0xAAAAAAAA, B=0x55555555 supplied with S_VALID held high -> contiguous 64-bit stream A,B with no gap; UNDERRUN stays 0; S_READY re-asserts 1 cycle after each boundary load.
- RUN, no word at a boundary -> idle word 0x69696969 inserted and UNDERRUN=1. A CLR_UNDERRUN pulse on a non-underrun cycle -> 0. A coincident new underrun and clear -> remains 1.
- EN dropped at bit 10 of a word, with a word already held -> the current word finishes all 32 bits, then the idle pattern follows. State is IDLE, hold discarded, S_READY=0.
- MRST asserted at bit 17 of a word -> outputs immediately at reset values. After release with EN=1, the first word starts only at a full boundary 32 fall ticks later.

Source files
------------

// File: rtl/snd_dsd_pkg.sv
// Shared types and constants for the DSD serializer: FSM states and
// the silence-word builder.
package snd_dsd_pkg;

   localparam int unsigned IDLE_W_MAX    = 256;
   localparam logic [7:0]  IDLE_BYTE_DEF = 8'h69;

   typedef enum logic [1:0] {
      IDLE,
      PRIME,
      RUN
   } dsd_state_t;

   // Replicates the silence byte word_w/8 times into the low bits of a
   // maximum-width vector; callers slice off the width they need.
   function automatic logic [IDLE_W_MAX-1:0] idle_word(input int unsigned word_w,
                                                      input logic [7:0]  idle_byte);
      logic [IDLE_W_MAX-1:0] w;
      w = '0;
      for (int unsigned i = 0; i < IDLE_W_MAX / 8; i++) begin
         if (i < word_w / 8) begin
            w[i*8 +: 8] = idle_byte;
         end
      end
      return w;
   endfunction

endpackage

// File: rtl/snd_dsd_chshift.sv
// One DSD channel: MSB-first shift register with word load, zero fill
// on shift and a registered MSB output.
module snd_dsd_chshift
   import snd_dsd_pkg::*;
#(
   parameter int unsigned       WORD_W   = 32,
   parameter logic [WORD_W-1:0] RST_WORD = '0
) (
   input  logic              MCLK,
   input  logic              MRST,
   input  logic              load,
   input  logic              shift,
   input  logic [WORD_W-1:0] load_word,
   output logic              msb
);

   logic [WORD_W-1:0] sreg;

   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         sreg <= RST_WORD;
      end else if (load) begin
         sreg <= load_word;
      end else if (shift) begin
         sreg <= {sreg[WORD_W-2:0], 1'b0};
      end
   end

   assign msb = sreg[WORD_W-1];

endmodule

// File: rtl/snd_dsd_serializer.sv
// Stereo DSD serializer: one-deep hold buffer fed by valid/ready, words
// shifted out MSB-first on BCLK falling ticks, silence on idle/starvation.
module snd_dsd_serializer
   import snd_dsd_pkg::*;
#(
   parameter int unsigned WORD_W    = 32,
   parameter logic [7:0]  IDLE_BYTE = IDLE_BYTE_DEF
) (
   input  logic              MCLK,
   input  logic              MRST,
   input  logic              BCLK,
   input  logic              EN,
   input  logic [WORD_W-1:0] S_DATA_L,
   input  logic [WORD_W-1:0] S_DATA_R,
   input  logic              S_VALID,
   output logic              S_READY,
   output logic              DSD_CLK,
   output logic              DSD_L,
   output logic              DSD_R,
   output logic              UNDERRUN,
   input  logic              CLR_UNDERRUN
);

   localparam logic [IDLE_W_MAX-1:0] IDLE_FULL = idle_word(WORD_W, IDLE_BYTE);
   localparam logic [WORD_W-1:0]     IDLE_WORD = IDLE_FULL[WORD_W-1:0];
   localparam int unsigned           CNT_W     = (WORD_W > 1) ? $clog2(WORD_W) : 1;
   localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(WORD_W - 1);

   dsd_state_t        state;
   dsd_state_t        state_nx;
   logic              bclk_d;
   logic              fall;
   logic              boundary;
   logic [CNT_W-1:0]  bitcnt;
   logic              hold_valid;
   logic [WORD_W-1:0] hold_l;
   logic [WORD_W-1:0] hold_r;
   logic              accept;
   logic              load_hold;
   logic              clr_hold;
   logic              set_underrun;
   logic [WORD_W-1:0] load_l;
   logic [WORD_W-1:0] load_r;

   // BCLK is only sampled; its falling edge becomes a one-MCLK tick.
   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         bclk_d <= 1'b0;
      end else begin
         bclk_d <= BCLK;
      end
   end

   assign fall     = bclk_d & ~BCLK;
   assign DSD_CLK  = bclk_d;
   assign boundary = fall && (bitcnt == LAST_BIT);

   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         bitcnt <= LAST_BIT;
      end else if (fall) begin
         if (bitcnt == LAST_BIT) begin
            bitcnt <= '0;
         end else begin
            bitcnt <= bitcnt + 1'b1;
         end
      end
   end

   assign S_READY = ~hold_valid & (state != IDLE);
   assign accept  = S_VALID & S_READY;

   // A discard at a disabled boundary overrides an accept in the same cycle.
   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         hold_valid <= 1'b0;
         hold_l     <= '0;
         hold_r     <= '0;
      end else begin
         if (clr_hold) begin
            hold_valid <= 1'b0;
         end else if (accept) begin
            hold_valid <= 1'b1;
         end
         if (accept) begin
            hold_l <= S_DATA_L;
            hold_r <= S_DATA_R;
         end
      end
   end

   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (EN) begin
               state_nx = PRIME;
            end
         end
         PRIME: begin
            if (boundary) begin
               if (!EN) begin
                  state_nx = IDLE;
               end else if (hold_valid) begin
                  state_nx = RUN;
               end
            end
         end
         RUN: begin
            if (boundary && !EN) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_comb begin
      load_hold    = 1'b0;
      clr_hold     = 1'b0;
      set_underrun = 1'b0;
      if (boundary) begin
         case (state)
            PRIME, RUN: begin
               if (!EN) begin
                  clr_hold = 1'b1;
               end else if (hold_valid) begin
                  load_hold = 1'b1;
                  clr_hold  = 1'b1;
               end else if (state == RUN) begin
                  set_underrun = 1'b1;
               end
            end
            default: begin
               load_hold = 1'b0;
            end
         endcase
      end
   end

   // Set takes priority over a coincident clear.
   always_ff @(posedge MCLK or negedge MRST) begin
      if (!MRST) begin
         UNDERRUN <= 1'b0;
      end else if (set_underrun) begin
         UNDERRUN <= 1'b1;
      end else if (CLR_UNDERRUN) begin
         UNDERRUN <= 1'b0;
      end
   end

   assign load_l = load_hold ? hold_l : IDLE_WORD;
   assign load_r = load_hold ? hold_r : IDLE_WORD;

   snd_dsd_chshift #(
      .WORD_W   (WORD_W),
      .RST_WORD (IDLE_WORD)
   ) u_shift_l (
      .MCLK      (MCLK),
      .MRST      (MRST),
      .load      (boundary),
      .shift     (fall & ~boundary),
      .load_word (load_l),
      .msb       (DSD_L)
   );

   snd_dsd_chshift #(
      .WORD_W   (WORD_W),
      .RST_WORD (IDLE_WORD)
   ) u_shift_r (
      .MCLK      (MCLK),
      .MRST      (MRST),
      .load      (boundary),
      .shift     (fall & ~boundary),
      .load_word (load_r),
      .msb       (DSD_R)
   );

endmodule

// File: tb/tb_snd_dsd_serializer.sv
// Directed bench for snd_dsd_serializer: words are reassembled from the
// serial outputs at each DSD_CLK falling step and compared to fixed values.
module tb_snd_dsd_serializer;

   logic        MCLK = 1'b0;
   logic        MRST = 1'b0;
   logic        BCLK = 1'b0;
   logic        EN = 1'b0;
   logic [31:0] S_DATA_L = 32'hDEADBEEF;
   logic [31:0] S_DATA_R = 32'hDEADBEEF;
   logic        S_VALID = 1'b0;
   logic        S_READY;
   logic        DSD_CLK;
   logic        DSD_L;
   logic        DSD_R;
   logic        UNDERRUN;
   logic        CLR_UNDERRUN = 1'b0;

   int          checks = 0;
   int          errors = 0;
   int          nfall = 0;
   logic        fell = 1'b0;
   logic [31:0] ql[$];
   logic [31:0] qr[$];

   snd_dsd_serializer #(
      .WORD_W    (32),
      .IDLE_BYTE (8'h69)
   ) dut (
      .MCLK         (MCLK),
      .MRST         (MRST),
      .BCLK         (BCLK),
      .EN           (EN),
      .S_DATA_L     (S_DATA_L),
      .S_DATA_R     (S_DATA_R),
      .S_VALID      (S_VALID),
      .S_READY      (S_READY),
      .DSD_CLK      (DSD_CLK),
      .DSD_L        (DSD_L),
      .DSD_R        (DSD_R),
      .UNDERRUN     (UNDERRUN),
      .CLR_UNDERRUN (CLR_UNDERRUN)
   );

   always #5 MCLK = ~MCLK;

   // Free-running MCLK/2 bit clock, as produced by the upstream divider.
   always @(posedge MCLK) BCLK <= ~BCLK;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive_q();
      if (ql.size() != 0) begin
         S_VALID  = 1'b1;
         S_DATA_L = ql[0];
         S_DATA_R = qr[0];
      end else begin
         S_VALID  = 1'b0;
         S_DATA_L = 32'hDEADBEEF;
         S_DATA_R = 32'hDEADBEEF;
      end
   endtask

   task automatic push(input logic [31:0] l, input logic [31:0] r);
      ql.push_back(l);
      qr.push_back(r);
      drive_q();
   endtask

   // Advance one MCLK, from negedge to negedge; notes DSD_CLK 1->0 steps
   // and retires the queued word the DUT accepted on the passing posedge.
   task automatic tick();
      logic prev;
      logic acc;
      prev = DSD_CLK;
      acc  = S_VALID && S_READY && MRST;
      @(negedge MCLK);
      fell = (prev === 1'b1) && (DSD_CLK === 1'b0);
      if (fell) nfall++;
      if (acc && ql.size() != 0) begin
         void'(ql.pop_front());
         void'(qr.pop_front());
      end
      drive_q();
   endtask

   function automatic int widx();
      return (nfall - 1) % 32;
   endfunction

   task automatic wait_idx(input int k, output logic ok);
      int n;
      n = 0;
      do begin
         tick();
         n++;
      end while (!(fell && widx() == k) && n < 200);
      ok = fell && (widx() == k);
   endtask

   // Capture the next full word starting at a word boundary; EN is dropped
   // right after bit drop_bit is seen. Each bit must last exactly two MCLK
   // with DSD_CLK high and data steady in its second half.
   task automatic read_word(input int drop_bit, output logic [31:0] wl, output logic [31:0] wr,
                            output logic rdy0, output logic ok);
      logic found;
      wl = '0;
      wr = '0;
      wait_idx(0, found);
      ok   = found;
      rdy0 = S_READY;
      for (int b = 0; b < 32; b++) begin
         if (b > 0) begin
            tick();
            if (!fell) ok = 1'b0;
         end
         wl[31-b] = DSD_L;
         wr[31-b] = DSD_R;
         if (b == drop_bit) EN = 1'b0;
         tick();
         if (fell || DSD_CLK !== 1'b1 || DSD_L !== wl[31-b] || DSD_R !== wr[31-b]) ok = 1'b0;
      end
   endtask

   initial begin
      logic [31:0] wl;
      logic [31:0] wr;
      logic        rdy0;
      logic        ok;

      // Reset with BCLK running and the stream disabled
      repeat (4) tick();
      chk("rst_dsd_l", DSD_L, 0);
      chk("rst_dsd_r", DSD_R, 0);
      chk("rst_dsd_clk", DSD_CLK, 0);
      chk("rst_ready", S_READY, 0);
      chk("rst_underrun", UNDERRUN, 0);
      MRST  = 1'b1;
      nfall = 0;
      read_word(32, wl, wr, rdy0, ok);
      chk("idle_timing", ok, 1);
      chk("idle_word_l", wl, 32'h69696969);
      chk("idle_word_r", wr, 32'h69696969);
      chk("idle_ready", S_READY, 0);
      chk("idle_underrun", UNDERRUN, 0);

      // Enable, one word held while priming, two more queued behind it
      EN = 1'b1;
      tick();
      chk("prime_ready", S_READY, 1);
      push(32'hF0F0F0F0, 32'h0000FFFF);
      tick();
      chk("held_ready", S_READY, 0);
      push(32'hAAAAAAAA, 32'h55555555);
      push(32'h55555555, 32'hAAAAAAAA);
      read_word(32, wl, wr, rdy0, ok);
      chk("w1_timing", ok, 1);
      chk("w1_l", wl, 32'hF0F0F0F0);
      chk("w1_r", wr, 32'h0000FFFF);
      chk("w1_ready_after_load", rdy0, 1);
      read_word(32, wl, wr, rdy0, ok);
      chk("wa_timing", ok, 1);
      chk("wa_l", wl, 32'hAAAAAAAA);
      chk("wa_r", wr, 32'h55555555);
      chk("wa_ready_after_load", rdy0, 1);
      read_word(32, wl, wr, rdy0, ok);
      chk("wb_timing", ok, 1);
      chk("wb_l", wl, 32'h55555555);
      chk("wb_r", wr, 32'hAAAAAAAA);
      chk("wb_ready_after_load", rdy0, 1);
      chk("b2b_underrun", UNDERRUN, 0);

      // Starvation in RUN
      read_word(32, wl, wr, rdy0, ok);
      chk("starve_timing", ok, 1);
      chk("starve_l", wl, 32'h69696969);
      chk("starve_r", wr, 32'h69696969);
      chk("starve_underrun", UNDERRUN, 1);
      repeat (3) tick();
      CLR_UNDERRUN = 1'b1;
      tick();
      CLR_UNDERRUN = 1'b0;
      chk("clr_underrun", UNDERRUN, 0);
      wait_idx(31, ok);
      chk("find_bit31", ok, 1);
      tick();
      CLR_UNDERRUN = 1'b1;
      tick();
      CLR_UNDERRUN = 1'b0;
      chk("set_beats_clr", UNDERRUN, 1);
      CLR_UNDERRUN = 1'b1;
      tick();
      CLR_UNDERRUN = 1'b0;
      chk("clr_again", UNDERRUN, 0);

      // EN dropped mid-word with a second word already held
      push(32'h12345678, 32'h9ABCDEF0);
      push(32'h0F1E2D3C, 32'hC3D2E1F0);
      read_word(10, wl, wr, rdy0, ok);
      chk("drain_timing", ok, 1);
      chk("drain_l", wl, 32'h12345678);
      chk("drain_r", wr, 32'h9ABCDEF0);
      read_word(32, wl, wr, rdy0, ok);
      chk("off_timing", ok, 1);
      chk("off_l", wl, 32'h69696969);
      chk("off_r", wr, 32'h69696969);
      chk("off_ready_at_load", rdy0, 0);
      chk("off_ready", S_READY, 0);
      chk("off_underrun", UNDERRUN, 0);

      // Reset in the middle of a word
      EN = 1'b1;
      push(32'hCAFEF00D, 32'h0000FFFF);
      repeat (4) tick();
      wait_idx(0, ok);
      chk("e_start", ok, 1);
      wait_idx(17, ok);
      chk("e_bit17_found", ok, 1);
      chk("e_bit17_l", DSD_L, 1);
      chk("e_bit17_r", DSD_R, 1);
      chk("e_ready", S_READY, 1);
      MRST = 1'b0;
      #1;
      chk("mid_rst_l", DSD_L, 0);
      chk("mid_rst_r", DSD_R, 0);
      chk("mid_rst_ready", S_READY, 0);
      ql.delete();
      qr.delete();
      drive_q();
      nfall = 0;
      repeat (3) tick();
      MRST = 1'b1;
      repeat (4) tick();
      push(32'h3C3C3C3C, 32'hC3C3C3C3);
      read_word(32, wl, wr, rdy0, ok);
      chk("post_rst_timing", ok, 1);
      chk("post_rst_l", wl, 32'h3C3C3C3C);
      chk("post_rst_r", wr, 32'hC3C3C3C3);
      chk("post_rst_underrun", UNDERRUN, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
